// File: rtl/ber_stat_accum.sv
// BER measurement controller: per-core frame results are summed through a
// registered adder tree and folded into saturating statistics totals.
module ber_stat_accum #(
    parameter int N_CORES    = 50,
    parameter int ERR_W      = 16,
    parameter int CNT_W      = 64,
    parameter int FRAME_BITS = 5440
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clear,
    input  logic [CNT_W-1:0]         stop_frames,
    input  logic [CNT_W-1:0]         stop_frame_errors,
    input  logic [N_CORES-1:0]       frame_valid,
    input  logic [N_CORES*ERR_W-1:0] err_pre,
    input  logic [N_CORES*ERR_W-1:0] err_post,
    output logic                     core_en,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         total_bits,
    output logic [CNT_W-1:0]         total_bit_errors_pre,
    output logic [CNT_W-1:0]         total_bit_errors_post,
    output logic [CNT_W-1:0]         total_frames,
    output logic [CNT_W-1:0]         total_frame_errors
);

    localparam int LG  = $clog2(N_CORES);
    localparam int P   = 1 << LG;
    localparam int LAT = 1 + LG;
    localparam int EW  = ERR_W + LG;
    localparam int FW  = $clog2(N_CORES + 1);
    localparam int BW  = FW + $clog2(FRAME_BITS + 1);
    localparam int M1  = (CNT_W > EW) ? CNT_W : EW;
    localparam int M2  = (M1 > BW) ? M1 : BW;
    localparam int AW  = M2 + 1;
    localparam int DW  = $clog2(LAT + 1);

    localparam logic [AW-1:0] SAT_V = {{(AW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   drain_cnt_q;

    logic            sample_en;
    logic            upd_en;
    logic            start_acc;
    logic            zero_tot;
    logic            drain_end;
    logic            flush;
    logic            stop_hit;

    // Heap-ordered tree: node i sums children 2i and 2i+1, leaves at P..2P-1.
    logic [EW-1:0]   pre_q  [1:2*P-1];
    logic [EW-1:0]   post_q [1:2*P-1];
    logic [FW-1:0]   frm_q  [1:2*P-1];
    logic [FW-1:0]   fe_q   [1:2*P-1];

    logic [EW-1:0]   lf_pre_d  [P];
    logic [EW-1:0]   lf_post_d [P];
    logic [FW-1:0]   lf_frm_d  [P];
    logic [FW-1:0]   lf_fe_d   [P];

    logic [CNT_W-1:0] bits_q, pre_tot_q, post_tot_q, frm_tot_q, fe_tot_q;
    logic [CNT_W-1:0] bits_d, pre_tot_d, post_tot_d, frm_tot_d, fe_tot_d;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [AW-1:0]    b
    );
        logic [AW-1:0] s;
        s = AW'(a) + b;
        if (s > SAT_V) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    assign sample_en = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign upd_en    = sample_en;
    assign start_acc = start && !clear &&
                       ((state_q == S_IDLE) || (state_q == S_DONE));
    assign zero_tot  = clear || start_acc;
    assign drain_end = (state_q == S_DRAIN) && (drain_cnt_q == DW'(LAT));
    assign flush     = zero_tot || drain_end;

    assign stop_hit = ((stop_frames != '0) &&
                       (frm_tot_q >= stop_frames)) ||
                      ((stop_frame_errors != '0) &&
                       (fe_tot_q >= stop_frame_errors));

    always_comb begin
        for (int k = 0; k < P; k++) begin
            lf_pre_d[k]  = '0;
            lf_post_d[k] = '0;
            lf_frm_d[k]  = '0;
            lf_fe_d[k]   = '0;
        end
        for (int k = 0; k < N_CORES; k++) begin
            if (sample_en && frame_valid[k]) begin
                lf_pre_d[k]  = EW'(err_pre[k*ERR_W +: ERR_W]);
                lf_post_d[k] = EW'(err_post[k*ERR_W +: ERR_W]);
                lf_frm_d[k]  = FW'(1);
                lf_fe_d[k]   = FW'(|err_post[k*ERR_W +: ERR_W]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 1; i < 2*P; i++) begin
                pre_q[i]  <= '0;
                post_q[i] <= '0;
                frm_q[i]  <= '0;
                fe_q[i]   <= '0;
            end
        end else begin
            for (int i = 1; i < P; i++) begin
                pre_q[i]  <= pre_q[2*i]  + pre_q[2*i+1];
                post_q[i] <= post_q[2*i] + post_q[2*i+1];
                frm_q[i]  <= frm_q[2*i]  + frm_q[2*i+1];
                fe_q[i]   <= fe_q[2*i]   + fe_q[2*i+1];
            end
            for (int k = 0; k < P; k++) begin
                pre_q[P+k]  <= lf_pre_d[k];
                post_q[P+k] <= lf_post_d[k];
                frm_q[P+k]  <= lf_frm_d[k];
                fe_q[P+k]   <= lf_fe_d[k];
            end
        end
    end

    always_comb begin
        bits_d     = bits_q;
        pre_tot_d  = pre_tot_q;
        post_tot_d = post_tot_q;
        frm_tot_d  = frm_tot_q;
        fe_tot_d   = fe_tot_q;
        if (upd_en) begin
            bits_d     = sat_add(bits_q, AW'(frm_q[1]) * AW'(FRAME_BITS));
            pre_tot_d  = sat_add(pre_tot_q, AW'(pre_q[1]));
            post_tot_d = sat_add(post_tot_q, AW'(post_q[1]));
            frm_tot_d  = sat_add(frm_tot_q, AW'(frm_q[1]));
            fe_tot_d   = sat_add(fe_tot_q, AW'(fe_q[1]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || zero_tot) begin
            bits_q     <= '0;
            pre_tot_q  <= '0;
            post_tot_q <= '0;
            frm_tot_q  <= '0;
            fe_tot_q   <= '0;
        end else begin
            bits_q     <= bits_d;
            pre_tot_q  <= pre_tot_d;
            post_tot_q <= post_tot_d;
            frm_tot_q  <= frm_tot_d;
            fe_tot_q   <= fe_tot_d;
        end
    end

    // DRAIN holds for LAT+1 cycles so the last RUN samples reach the totals.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
            core_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        core_en <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop_hit) begin
                        state_q     <= S_DRAIN;
                        core_en     <= 1'b0;
                        drain_cnt_q <= '0;
                    end
                end
                S_DRAIN: begin
                    if (drain_end) begin
                        state_q <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign total_bits            = bits_q;
    assign total_bit_errors_pre  = pre_tot_q;
    assign total_bit_errors_post = post_tot_q;
    assign total_frames          = frm_tot_q;
    assign total_frame_errors    = fe_tot_q;

endmodule

// File: tb/tb_ber_stat_accum.sv
// Scoreboard bench for ber_stat_accum: a 64-bit default build plus an
// 8-bit build used for the saturation case.
module tb_ber_stat_accum;

    localparam int N  = 50;
    localparam int EW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start, clear;
    logic [63:0]     stop_f, stop_fe;
    logic [N-1:0]    fv;
    logic [N*EW-1:0] pre, post;
    logic            core_en, busy, done;
    logic [63:0]     t_bits, t_pre, t_post, t_frm, t_fe;

    logic            start8, clear8;
    logic [7:0]      stop_f8, stop_fe8;
    logic [N-1:0]    fv8;
    logic [N*EW-1:0] pre8, post8;
    logic            core_en8, busy8, done8;
    logic [7:0]      t8_bits, t8_pre, t8_post, t8_frm, t8_fe;

    ber_stat_accum dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .stop_frames(stop_f), .stop_frame_errors(stop_fe),
        .frame_valid(fv), .err_pre(pre), .err_post(post),
        .core_en(core_en), .busy(busy), .done(done),
        .total_bits(t_bits), .total_bit_errors_pre(t_pre),
        .total_bit_errors_post(t_post), .total_frames(t_frm),
        .total_frame_errors(t_fe)
    );

    ber_stat_accum #(.N_CORES(N), .ERR_W(EW), .CNT_W(8), .FRAME_BITS(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .clear(clear8),
        .stop_frames(stop_f8), .stop_frame_errors(stop_fe8),
        .frame_valid(fv8), .err_pre(pre8), .err_post(post8),
        .core_en(core_en8), .busy(busy8), .done(done8),
        .total_bits(t8_bits), .total_bit_errors_pre(t8_pre),
        .total_bit_errors_post(t8_post), .total_frames(t8_frm),
        .total_frame_errors(t8_fe)
    );

    typedef struct packed {
        logic [63:0] frm;
        logic [63:0] bits;
        logic [63:0] pre;
        logic [63:0] post;
        logic [63:0] fe;
    } tot_t;

    tot_t exp_q[$];
    tot_t exp8_q[$];
    tot_t last0 = '0;
    tot_t last8 = '0;
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic tot_t mk(longint f, longint b, longint p, longint q, longint e);
        tot_t t;
        t.frm = f; t.bits = b; t.pre = p; t.post = q; t.fe = e;
        return t;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic cmp_tot(string nm, tot_t a, tot_t e);
        chk({nm, ".frames"}, a.frm, e.frm);
        chk({nm, ".bits"}, a.bits, e.bits);
        chk({nm, ".pre"}, a.pre, e.pre);
        chk({nm, ".post"}, a.post, e.post);
        chk({nm, ".ferr"}, a.fe, e.fe);
    endtask

    // Monitors: any change of the totals is an output event to be matched.
    always @(negedge clk) begin
        tot_t cur;
        tot_t e;
        cur = {t_frm, t_bits, t_pre, t_post, t_fe};
        if (!rst && cur !== last0) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL upd64: unexpected update frames=%0d pre=%0d", t_frm, t_pre);
            end else begin
                e = exp_q.pop_front();
                cmp_tot("upd64", cur, e);
            end
        end
        last0 = cur;
    end

    always @(negedge clk) begin
        tot_t cur;
        tot_t e;
        cur = {56'd0, t8_frm, 56'd0, t8_bits, 56'd0, t8_pre, 56'd0, t8_post, 56'd0, t8_fe};
        if (!rst && cur !== last8) begin
            if (exp8_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL upd8: unexpected update frames=%0d pre=%0d", t8_frm, t8_pre);
            end else begin
                e = exp8_q.pop_front();
                cmp_tot("upd8", cur, e);
            end
        end
        last8 = cur;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_in();
        fv = '0; pre = '0; post = '0;
    endtask

    task automatic set_all(logic [15:0] pv, logic [15:0] qv);
        fv = '1;
        for (int k = 0; k < N; k++) begin
            pre[k*EW +: EW]  = pv;
            post[k*EW +: EW] = qv;
        end
    endtask

    task automatic one_core(int c, logic [15:0] pv, logic [15:0] qv);
        idle_in();
        fv[c] = 1'b1;
        pre[c*EW +: EW]  = pv;
        post[c*EW +: EW] = qv;
    endtask

    task automatic wait_drain(string nm);
        int cyc;
        cyc = 0;
        while (!(busy && !core_en) && cyc < 40) begin
            tick(); cyc++;
        end
        if (cyc >= 40) begin
            n_chk++; n_fail++;
            $display("FAIL %s: no DRAIN within 40 cycles", nm);
        end
    endtask

    task automatic wait_done(string nm);
        int cyc;
        cyc = 0;
        while (!done && cyc < 40) begin
            tick(); cyc++;
        end
        if (cyc >= 40) begin
            n_chk++; n_fail++;
            $display("FAIL %s: no DONE within 40 cycles", nm);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; clear = 1'b0;
        stop_f = '0; stop_fe = '0;
        idle_in();
        start8 = 1'b0; clear8 = 1'b0; stop_f8 = '0; stop_fe8 = '0;
        fv8 = '0; pre8 = '0; post8 = '0;
        repeat (3) tick();
        chk("rst.core_en", 64'(core_en), 0);
        chk("rst.busy", 64'(busy), 0);
        chk("rst.done", 64'(done), 0);
        chk("rst.frames", t_frm, 0);
        chk("rst.bits", t_bits, 0);
        chk("rst.pre", t_pre, 0);
        rst = 1'b0;
        tick();

        // Frame-count stop with all cores strobing: 11 samples land.
        stop_f = 100; stop_fe = 0;
        set_all(16'd3, 16'd0);
        for (int k = 1; k <= 11; k++)
            exp_q.push_back(mk(50*k, 272000*k, 150*k, 0, 0));
        start = 1'b1; tick(); start = 1'b0;
        chk("run.core_en", 64'(core_en), 1);
        chk("run.busy", 64'(busy), 1);
        wait_drain("t1.drain");
        dc = 0;
        while (busy && dc < 40) begin
            tick(); dc++;
        end
        chk("t1.drain_len", 64'(dc), 8);
        chk("t1.done", 64'(done), 1);
        chk("t1.core_en", 64'(core_en), 0);
        chk("t1.frames", t_frm, 550);
        chk("t1.frames_mod50", t_frm % 50, 0);
        chk("t1.bits", t_bits, 550 * 5440);
        chk("t1.pre", t_pre, 3 * 550);
        chk("t1.ferr", t_fe, 0);

        // Inputs in DONE, then in IDLE, must not reach the totals.
        repeat (10) tick();
        chk("done_mask.frames", t_frm, 550);
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr.busy", 64'(busy), 0);
        chk("clr.done", 64'(done), 0);
        set_all(16'd5, 16'd1);
        repeat (10) tick();
        chk("idle_mask.pre", t_pre, 0);
        chk("idle_mask.ferr", t_fe, 0);
        idle_in();

        // Single frame from core 7: exact latency, start in RUN ignored.
        stop_f = 0; stop_fe = 1;
        start = 1'b1; tick(); start = 1'b0;
        one_core(7, 16'd9, 16'd1);
        exp_q.push_back(mk(1, 5440, 9, 1, 1));
        tick();
        idle_in();
        for (int k = 1; k <= 6; k++) begin
            if (k == 2) start = 1'b1;
            tick();
            start = 1'b0;
            chk("lat.early", t_frm, 0);
        end
        tick();
        chk("lat.frames", t_frm, 1);
        chk("lat.pre", t_pre, 9);
        chk("lat.post", t_post, 1);
        chk("lat.ferr", t_fe, 1);
        wait_done("t2.done");
        chk("t2.done", 64'(done), 1);

        // Clear in the 3rd DRAIN cycle flushes in-flight results.
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        stop_f = 100; stop_fe = 0;
        set_all(16'd3, 16'd0);
        for (int k = 1; k <= 5; k++)
            exp_q.push_back(mk(50*k, 272000*k, 150*k, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        start = 1'b1; tick(); start = 1'b0;
        wait_drain("t3.drain");
        tick();
        tick();
        clear = 1'b1; tick(); clear = 1'b0;
        chk("dclr.frames", t_frm, 0);
        chk("dclr.busy", 64'(busy), 0);
        chk("dclr.core_en", 64'(core_en), 0);
        chk("dclr.done", 64'(done), 0);
        repeat (15) tick();
        chk("dclr.after", t_frm, 0);
        idle_in();

        // start together with clear from DONE: clear wins.
        stop_f = 0; stop_fe = 1;
        start = 1'b1; tick(); start = 1'b0;
        one_core(3, 16'd2, 16'd5);
        exp_q.push_back(mk(1, 5440, 2, 5, 1));
        tick();
        idle_in();
        wait_done("t4.done");
        chk("t4.done", 64'(done), 1);
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
        chk("sc.busy", 64'(busy), 0);
        chk("sc.done", 64'(done), 0);
        chk("sc.frames", t_frm, 0);
        chk("sc.post", t_post, 0);
        repeat (5) tick();
        chk("sc.idle", 64'(busy), 0);

        // 8-bit build: pre saturates at 255, other totals keep counting.
        start8 = 1'b1; tick(); start8 = 1'b0;
        fv8 = '0; fv8[0] = 1'b1; fv8[1] = 1'b1;
        pre8[0 +: EW] = 16'd100; pre8[EW +: EW] = 16'd100;
        exp8_q.push_back(mk(2, 2, 200, 0, 0));
        tick();
        fv8 = '0; pre8 = '0; fv8[0] = 1'b1;
        pre8[0 +: EW] = 16'd100; post8[0 +: EW] = 16'd1;
        exp8_q.push_back(mk(3, 3, 255, 1, 1));
        tick();
        fv8 = '0; pre8 = '0; post8 = '0;
        for (int k = 0; k < 4; k++) begin
            fv8[k] = 1'b1;
            pre8[k*EW +: EW]  = 16'd7;
            post8[k*EW +: EW] = 16'd2;
        end
        exp8_q.push_back(mk(7, 7, 255, 9, 5));
        tick();
        fv8 = '0; pre8 = '0; post8 = '0;
        repeat (12) tick();
        chk("sat.pre", 64'(t8_pre), 255);
        chk("sat.frames", 64'(t8_frm), 7);
        chk("sat.post", 64'(t8_post), 9);

        repeat (5) tick();
        chk("q64.drained", 64'(exp_q.size()), 0);
        chk("q8.drained", 64'(exp8_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ber_stat_accum.md
BER_STAT_ACCUM -- requirements
Module: ber_stat_accum

Interface
REQ-001 Parameter N_CORES, default 50: number of parallel decoder cores reporting frame results.
REQ-002 Parameter ERR_W, default 16: width of each per-core per-frame bit-error count.
REQ-003 Parameter CNT_W, default 64: width of every accumulated total.
REQ-004 Parameter FRAME_BITS, default 5440: bits per frame added to total_bits per valid frame.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle pulse; begins a new measurement run.
REQ-008 clear  in  1  single-cycle pulse; aborts the run and zeroes totals.
REQ-009 stop_frames  in  CNT_W  frame-count stop threshold; 0 = disabled.
REQ-010 stop_frame_errors  in  CNT_W  frame-error stop threshold; 0 = disabled.
REQ-011 frame_valid  in  N_CORES  per-core strobe; the core finished one frame this cycle.
REQ-012 err_pre  in  N_CORES*ERR_W  per-core pre-FEC bit errors; core k occupies bits [k*ERR_W +: ERR_W].
REQ-013 err_post  in  N_CORES*ERR_W  per-core post-FEC bit errors; same packing.
REQ-014 core_en  out  1  enable broadcast to all cores.
REQ-015 busy  out  1  high in RUN or DRAIN.
REQ-016 done  out  1  high in DONE.
REQ-017 total_bits, total_bit_errors_pre, total_bit_errors_post, total_frames, total_frame_errors  out  CNT_W each  accumulated statistics.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN, DONE. core_en=1 only in RUN.
REQ-019 IDLE/DONE + start: zero all totals, move to RUN on the next edge.
REQ-020 start in RUN or DRAIN is ignored.
REQ-021 clear in any state: zero all totals, move to IDLE. clear has priority over start.
REQ-022 Per cycle, a core whose frame_valid is set contributes 1 frame, FRAME_BITS bits, its err_pre, its err_post, and 1 frame error if err_post != 0. Cores with frame_valid=0 contribute nothing, regardless of their err inputs.
REQ-023 Reduction is a registered pipeline: one input register stage, then a registered adder tree of depth ceil(log2(N_CORES)). LAT = 1 + ceil(log2(N_CORES)) (7 for N_CORES=50) is the fixed latency from sampling frame_valid to the totals update.
REQ-024 Results are sampled into the pipeline only in RUN and DRAIN. In IDLE and DONE, inputs are masked at the pipeline entry.
REQ-025 Adder-tree intermediate widths are sized to prevent overflow: ERR_W + ceil(log2(N_CORES)) for errors, ceil(log2(N_CORES+1)) for frame counts.
REQ-026 Each total saturates at 2^CNT_W-1 and never wraps. Saturation is independent per total.
REQ-027 Stop condition, evaluated on the registered totals in RUN: (stop_frames!=0 and total_frames>=stop_frames) or (stop_frame_errors!=0 and total_frame_errors>=stop_frame_errors).
REQ-028 With both thresholds at 0, the run continues until clear.
REQ-029 On the stop condition, RUN->DRAIN. core_en falls in the same cycle the state becomes DRAIN.
REQ-030 DRAIN lasts exactly LAT+1 cycles so in-flight results are counted, then ->DONE. Totals may therefore exceed the thresholds.
REQ-031 DONE holds totals and done=1 until start or clear.
REQ-032 clear mid-DRAIN flushes the pipeline: in-flight results are discarded and no totals update afterwards.
REQ-033 The pipeline is flushed on start, clear and rst.

Reset
REQ-034 While rst=1: state=IDLE, pipeline registers zeroed, and core_en, busy, done and all totals are 0.
REQ-035 rst has priority over start and clear. The first valid start is accepted on the cycle after rst deasserts.

Verification
REQ-036 rst, then start with stop_frames=100 and stop_frame_errors=0; all 50 cores strobe every cycle with err_pre=3, err_post=0. Required: RUN->DRAIN when total_frames>=100; final totals are integer multiples of 50 frames; total_bits=frames*5440; total_bit_errors_pre=3*frames; total_frame_errors=0; done=1.
REQ-037 Only core 7 strobes, once, with err_post=1 and err_pre=9, stop_frame_errors=1. Required: totals update exactly LAT=7 cycles later to frames=1, pre=9, post=1, frame_errors=1; the FSM then drains and reaches DONE.
REQ-038 Inputs strobed while in IDLE and in DONE. Required: totals remain unchanged.
REQ-039 clear asserted in the 3rd cycle of DRAIN. Required: totals read 0 on the next cycle, state=IDLE, core_en=0, and no later updates.
REQ-040 Totals preset near saturation (CNT_W=8 build), then inputs that push total_bit_errors_pre past 255. Required: the total holds at 255 while the other totals continue to count.
REQ-041 start and clear asserted in the same cycle from DONE. Required: state=IDLE, totals 0.
